// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional feature macro: INSTR_MEM_LOADER_CHECKSUM_EN (adds the CHECK state).
package riscv_pkg;

    localparam int unsigned DEFAULT_DEPTH = 32;
    localparam int unsigned BYTE_CNT_W    = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_LOAD,
        ST_WRITE,
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
        ST_CHECK,
`endif
        ST_DONE
    } loader_state_e;

endpackage

// File: rtl/instr_word_assembler.sv
// Little-endian byte-to-word assembler: byte-lane counter plus shift register.
// The first byte of a word ends up in word_c[7:0], the fourth in word_c[31:24].
module instr_word_assembler
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_data,
    output logic [31:0] word_c,
    output logic        last_c
);

    // The fourth byte is combined directly, so only three bytes are held.
    logic [BYTE_CNT_W-1:0] lane;
    logic [23:0]           shreg;

    assign last_c = accept & (lane == BYTE_CNT_W'(3));
    assign word_c = {byte_data, shreg};

    // Shift each accepted byte in from the top; lane counter wraps after the fourth byte.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lane  <= '0;
            shreg <= '0;
        end else if (accept) begin
            lane  <= lane + BYTE_CNT_W'(1);
            shreg <= {byte_data, shreg[23:8]};
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Byte-stream loader that fills instruction memory one 32-bit word at a time.
// Session: start, length byte N, then 4*N little-endian bytes.
// Optional feature macro: INSTR_MEM_LOADER_CHECKSUM_EN appends an XOR checksum byte.
module instr_mem_loader
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    loader_state_e state;
    logic [7:0]    n_words;
    logic [7:0]    word_cnt;
    logic          accept_c;
    logic          load_accept_c;
    logic          start_c;
    logic          last_c;
    logic [31:0]   word_c;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    assign accept_c      = byte_valid & byte_ready;
    assign load_accept_c = accept_c & (state == ST_LOAD);
    assign start_c       = start & (state == ST_IDLE);

    instr_word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_c),
        .accept    (load_accept_c),
        .byte_data (byte_data),
        .word_c    (word_c),
        .last_c    (last_c)
    );

    // Session FSM with registered handshake, write-port and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            n_words    <= '0;
            word_cnt   <= '0;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            done  <= 1'b0;
            wr_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        word_cnt   <= '0;
                        wr_addr    <= '0;
                        err        <= 1'b0;
                        busy       <= 1'b1;
                        byte_ready <= 1'b1;
                        state      <= ST_LEN;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
                        csum       <= '0;
`endif
                    end
                end
                ST_LEN: begin
                    if (accept_c) begin
                        n_words <= byte_data;
                        if (byte_data == 8'd0) begin
                            byte_ready <= 1'b0;
                            state      <= ST_DONE;
                        end else if (32'(byte_data) > DEPTH) begin
                            err        <= 1'b1;
                            busy       <= 1'b0;
                            byte_ready <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept_c) begin
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
                        csum <= csum ^ byte_data;
`endif
                        if (last_c) begin
                            wr_data    <= word_c;
                            wr_en      <= 1'b1;
                            byte_ready <= 1'b0;
                            state      <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    // Address saturates at the last word of memory.
                    if (wr_addr != ADDR_W'(DEPTH - 1)) begin
                        wr_addr <= wr_addr + ADDR_W'(1);
                    end
                    word_cnt <= word_cnt + 8'd1;
                    if ((word_cnt + 8'd1) < n_words) begin
                        byte_ready <= 1'b1;
                        state      <= ST_LOAD;
                    end else begin
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
                        byte_ready <= 1'b1;
                        state      <= ST_CHECK;
`else
                        state      <= ST_DONE;
`endif
                    end
                end
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (accept_c) begin
                        byte_ready <= 1'b0;
                        if (byte_data == csum) begin
                            state <= ST_DONE;
                        end else begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                end
`endif
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    byte_ready <= 1'b0;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader (default DEPTH=32).
// Define INSTR_MEM_LOADER_CHECKSUM_EN for both RTL and bench to exercise the checksum.
module tb_instr_mem_loader;

    localparam int unsigned DEPTH  = 32;
    localparam int unsigned ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              done;
    logic              err;

    instr_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [7:0]  tb_xor;
    int wbase;
    int dbase;

    // Record every write strobe and done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_en) begin
            log_addr.push_back(32'(wr_addr));
            log_data.push_back(wr_data);
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] get_addr(input int i);
        return (i < log_addr.size()) ? log_addr[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] get_data(input int i);
        return (i < log_data.size()) ? log_data[i] : 32'hDEAD_BEEF;
    endfunction

    // Snapshot write/done counters while the loader is idle.
    task automatic mark();
        @(negedge clk);
        #1;
        wbase = log_addr.size();
        dbase = done_cnt;
    endtask

    task automatic pulse_start();
        tb_xor = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte and return at the negedge after it is accepted.
    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        byte_data  = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 32 && !ok; i++) begin
            if (byte_ready) ok = 1'b1;
            @(negedge clk);
        end
        byte_valid = 1'b0;
        if (!ok) check("byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic load_byte(input logic [7:0] b);
        tb_xor = tb_xor ^ b;
        send_byte(b);
    endtask

    task automatic send_csum();
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
        send_byte(tb_xor);
`endif
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; tb_xor = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_wr_en",      32'(wr_en),      32'd0);
        check("rst_wr_addr",    32'(wr_addr),    32'd0);
        check("rst_wr_data",    wr_data,         32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_err",        32'(err),        32'd0);
        reset = 1'b0;

        // Two words, back-to-back bytes
        mark();
        pulse_start();
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_ready", 32'(byte_ready), 32'd1);
        send_byte(8'd2);
        load_byte(8'h13); load_byte(8'h00); load_byte(8'h10); load_byte(8'h00);
        check("t1_lat_wr_en", 32'(wr_en), 32'd1);
        check("t1_lat_addr", 32'(wr_addr), 32'd0);
        check("t1_lat_data", wr_data, 32'h0010_0013);
        load_byte(8'h93); load_byte(8'h00); load_byte(8'h20); load_byte(8'h00);
        send_csum();
        repeat (4) @(negedge clk);
        check("t1_nwr", 32'(log_addr.size() - wbase), 32'd2);
        check("t1_a0", get_addr(wbase), 32'd0);
        check("t1_d0", get_data(wbase), 32'h0010_0013);
        check("t1_a1", get_addr(wbase + 1), 32'd1);
        check("t1_d1", get_data(wbase + 1), 32'h0020_0093);
        check("t1_done", 32'(done_cnt - dbase), 32'd1);
        check("t1_err", 32'(err), 32'd0);
        check("t1_busy_end", 32'(busy), 32'd0);

        // N=0: done two cycles after the length byte, no writes
        mark();
        pulse_start();
        send_byte(8'd0);
        check("t2_done_c1", 32'(done), 32'd0);
        @(negedge clk);
        check("t2_done_c2", 32'(done), 32'd1);
        check("t2_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("t2_done_c3", 32'(done), 32'd0);
        check("t2_nwr", 32'(log_addr.size() - wbase), 32'd0);

        // N=33 exceeds depth
        mark();
        pulse_start();
        send_byte(8'd33);
        check("t3_err", 32'(err), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_ready", 32'(byte_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("t3_nwr", 32'(log_addr.size() - wbase), 32'd0);
        check("t3_done", 32'(done_cnt - dbase), 32'd0);
        check("t3_err_sticky", 32'(err), 32'd1);

        // Stall inside a word, with an ignored start while busy
        mark();
        pulse_start();
        check("t4_err_clr", 32'(err), 32'd0);
        send_byte(8'd1);
        load_byte(8'h11); load_byte(8'h22);
        pulse_start();
        tb_xor = 8'h11 ^ 8'h22;
        repeat (4) @(negedge clk);
        check("t4_stall_busy", 32'(busy), 32'd1);
        check("t4_stall_ready", 32'(byte_ready), 32'd1);
        check("t4_stall_wr_en", 32'(wr_en), 32'd0);
        load_byte(8'h33); load_byte(8'h44);
        send_csum();
        repeat (4) @(negedge clk);
        check("t4_nwr", 32'(log_addr.size() - wbase), 32'd1);
        check("t4_a0", get_addr(wbase), 32'd0);
        check("t4_d0", get_data(wbase), 32'h4433_2211);
        check("t4_done", 32'(done_cnt - dbase), 32'd1);

        // Reset after the third byte of a word
        mark();
        pulse_start();
        send_byte(8'd1);
        load_byte(8'hAA); load_byte(8'hBB); load_byte(8'hCC);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_ready", 32'(byte_ready), 32'd0);
        check("t5_wr_data", wr_data, 32'd0);
        repeat (3) @(negedge clk);
        check("t5_nwr_abort", 32'(log_addr.size() - wbase), 32'd0);
        check("t5_done_abort", 32'(done_cnt - dbase), 32'd0);
        pulse_start();
        send_byte(8'd1);
        load_byte(8'h01); load_byte(8'h02); load_byte(8'h03); load_byte(8'h04);
        send_csum();
        repeat (4) @(negedge clk);
        check("t5_nwr", 32'(log_addr.size() - wbase), 32'd1);
        check("t5_a0", get_addr(wbase), 32'd0);
        check("t5_d0", get_data(wbase), 32'h0403_0201);

        // N=DEPTH fills memory; address stops at the last word
        mark();
        pulse_start();
        send_byte(8'(DEPTH));
        for (int w = 0; w < 32; w++) begin
            for (int b = 0; b < 4; b++) load_byte(8'(w * 4 + b));
        end
        send_csum();
        repeat (4) @(negedge clk);
        check("t6_nwr", 32'(log_addr.size() - wbase), 32'd32);
        check("t6_d0", get_data(wbase), 32'h0302_0100);
        check("t6_a31", get_addr(wbase + 31), 32'd31);
        check("t6_d31", get_data(wbase + 31), 32'h7F7E_7D7C);
        check("t6_addr_sat", 32'(wr_addr), 32'd31);
        check("t6_done", 32'(done_cnt - dbase), 32'd1);
        check("t6_err", 32'(err), 32'd0);

`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
        // Checksum match then mismatch
        mark();
        pulse_start();
        send_byte(8'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
        send_byte(8'h0F);
        repeat (3) @(negedge clk);
        check("t7_ok_done", 32'(done_cnt - dbase), 32'd1);
        check("t7_ok_err", 32'(err), 32'd0);
        mark();
        pulse_start();
        send_byte(8'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
        send_byte(8'h0E);
        repeat (3) @(negedge clk);
        check("t7_bad_err", 32'(err), 32'd1);
        check("t7_bad_done", 32'(done_cnt - dbase), 32'd0);
        check("t7_bad_busy", 32'(busy), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
